mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single NPC memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Allows one outstanding transaction at a time.
- Routes each response back to the requester that issued it.
- Gives LSU priority, with a starvation bound for IFU and a response timeout that returns an error instead of hanging the core.
- Sits between the fetch/LSU stages and the memory model/bus bridge.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width. Write mask width is DATA_W/8.
- MAX_LSU_STREAK, 4, number of consecutive LSU grants while IFU is waiting after which IFU must win.
- TIMEOUT, 255, cycles waited in RESP before an error response is forced. Must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ifu_req_valid  in  1  IFU request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address (read only).
- ifu_resp_valid  out  1  IFU response.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_resp_err  out  1  IFU response is a timeout error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte enables.
- lsu_resp_valid  out  1  LSU response.
- lsu_rdata  out  DATA_W  load data.
- lsu_resp_err  out  1  LSU timeout error.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  registered address.
- mem_wen  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_wmask  out  DATA_W/8  registered mask.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states:
  - IDLE: accepts requests.
  - REQ: mem_req_valid=1, waiting for mem_req_ready.
  - RESP: waiting for mem_resp_valid.
- Reset (rst_n=0 at a clock edge), from any state including mid-transaction:
  - state=IDLE, owner=IFU, streak=0, timer=0.
  - mem_addr/mem_wdata/mem_wmask=0, mem_wen=0.
  - Every *_valid, *_ready, *_err output and busy=0.
  - An in-flight memory response arriving after reset is dropped.
- Arbitration, IDLE only:
  - LSU wins when lsu_req_valid and not (ifu_req_valid and streak==MAX_LSU_STREAK). Otherwise IFU wins if ifu_req_valid.
  - Winner's *_ready=1 combinationally. Loser's ready=0. Both readies are 0 outside IDLE.
- Streak counter:
  - Increments on an LSU grant while ifu_req_valid=1.
  - Clears on an IFU grant, or on an LSU grant with ifu_req_valid=0.
  - Saturates at MAX_LSU_STREAK.
- Grant handshake (valid&ready in IDLE):
  - Latch addr/wen/wdata/wmask into the mem_* registers. IFU grants latch wen=0 and wmask=0.
  - Latch owner. Go to REQ next cycle.
  - mem_req_valid rises 1 cycle after grant.
- REQ: mem_req_valid held with stable payload until mem_req_ready=1. Then go to RESP, timer=0.
- RESP:
  - The owner's resp_valid equals mem_resp_valid, rdata=mem_rdata, err=0, combinationally in the same cycle. Then go to IDLE.
  - The non-owner's resp_valid stays 0.
  - If timer==TIMEOUT-1 with no mem_resp_valid: the owner's resp_valid=1, err=1, rdata=0 that cycle, then IDLE.
  - Otherwise timer increments.
- Responses are single-cycle pulses; requesters cannot stall them.
- mem_resp_valid is ignored in IDLE and REQ, including late responses after a timeout.
- Minimum turnaround: grant N, mem req N+1 (ready same cycle), RESP N+2 (resp same cycle), IDLE N+3, next grant N+3.
- Stores still produce a response; rdata is don't-care and err=0.

Test Plan:
- Reset mid-RESP: assert rst_n=0 for 1 cycle while in RESP, then mem_resp_valid=1 → no resp_valid on either side, busy=0, all outputs 0.
- IFU-only fetch: ifu_addr=0x80000000, mem_req_ready=1, mem responds next cycle with 0x00100073 → mem_req_valid at grant+1 with addr 0x80000000, wen=0; ifu_resp_valid at grant+2 with rdata 0x00100073, err=0.
- Simultaneous requests with streak<MAX: both valid → lsu_req_ready=1, ifu_req_ready=0; LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F appears on mem_*.
- Starvation bound: IFU and LSU held valid continuously with MAX_LSU_STREAK=4 → grant order LSU,LSU,LSU,LSU,IFU,LSU…
- Backpressure: mem_req_ready=0 for 5 cycles → mem_req_valid and payload stable for all 5 cycles; no readies asserted; busy=1.
- Timeout: TIMEOUT=8, no mem_resp_valid → owner resp_valid=1, err=1, rdata=0 exactly 8 cycles after entering RESP; a later mem_resp_valid produces no output.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
// LSU has priority, IFU has a starvation bound, and a stuck response times out.
module mem_port_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MAX_LSU_STREAK = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int MW = DATA_W / 8;
    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner_lsu;
    logic [SW-1:0]     r_streak;
    logic [TW-1:0]     r_timer;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MW-1:0]     r_wmask;

    logic w_idle;
    logic w_resp_st;
    logic w_ifu_block;
    logic w_lsu_win;
    logic w_ifu_win;
    logic w_timeout;
    logic w_resp_fire;
    logic w_ifu_resp;
    logic w_lsu_resp;

    // Combinational outputs are held low while reset is asserted.
    assign w_idle      = (r_state == S_IDLE) && rst_n;
    assign w_resp_st   = (r_state == S_RESP) && rst_n;
    assign w_ifu_block = ifu_req_valid
                         && (r_streak == SW'(MAX_LSU_STREAK));
    assign w_lsu_win   = w_idle && lsu_req_valid && !w_ifu_block;
    assign w_ifu_win   = w_idle && ifu_req_valid && !w_lsu_win;

    assign w_timeout   = w_resp_st && !mem_resp_valid
                         && (r_timer == TW'(TIMEOUT - 1));
    assign w_resp_fire = w_resp_st && (mem_resp_valid || w_timeout);
    assign w_ifu_resp  = w_resp_fire && !r_owner_lsu;
    assign w_lsu_resp  = w_resp_fire && r_owner_lsu;

    assign ifu_req_ready  = w_ifu_win;
    assign lsu_req_ready  = w_lsu_win;

    assign ifu_resp_valid = w_ifu_resp;
    assign ifu_resp_err   = w_ifu_resp && w_timeout;
    assign ifu_rdata      = (w_ifu_resp && mem_resp_valid) ? mem_rdata : '0;

    assign lsu_resp_valid = w_lsu_resp;
    assign lsu_resp_err   = w_lsu_resp && w_timeout;
    assign lsu_rdata      = (w_lsu_resp && mem_resp_valid) ? mem_rdata : '0;

    assign mem_req_valid  = (r_state == S_REQ) && rst_n;
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_lsu <= 1'b0;
            r_streak    <= '0;
            r_timer     <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lsu_win) begin
                        r_addr      <= lsu_addr;
                        r_wen       <= lsu_wen;
                        r_wdata     <= lsu_wdata;
                        r_wmask     <= lsu_wmask;
                        r_owner_lsu <= 1'b1;
                        r_state     <= S_REQ;
                        // Count only grants that made a waiting IFU lose.
                        if (!ifu_req_valid) begin
                            r_streak <= '0;
                        end else if (r_streak != SW'(MAX_LSU_STREAK)) begin
                            r_streak <= r_streak + SW'(1);
                        end
                    end else if (w_ifu_win) begin
                        r_addr      <= ifu_addr;
                        r_wen       <= 1'b0;
                        r_wdata     <= '0;
                        r_wmask     <= '0;
                        r_owner_lsu <= 1'b0;
                        r_state     <= S_REQ;
                        r_streak    <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_RESP;
                        r_timer <= '0;
                    end
                end
                S_RESP: begin
                    if (mem_resp_valid || w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
